// File: rtl/fir_cfg_loader.sv
// fir_cfg_loader
// Holds one FIR configuration image written by the host and replays it as a
// single isConfig burst into the FIR control block, then waits for the
// acknowledge / completion handshake and reports ok, missing ACK or timeout.
module fir_cfg_loader #(
    parameter int FIR_CONFIG_DATA_WIDTH = 16,
    parameter int FILTER_MAX_ORDER      = 256,
    parameter int ADDR_WIDTH            = 10,
    parameter int TIMEOUT_CYCLES        = 1023
) (
    input  logic                             CLK,
    input  logic                             nRST,
    input  logic                             Cfg_Wr_En,
    input  logic [ADDR_WIDTH-1:0]            Cfg_Wr_Addr,
    input  logic [FIR_CONFIG_DATA_WIDTH-1:0] Cfg_Wr_Data,
    input  logic                             Cfg_Start,
    output logic                             Cfg_Busy,
    output logic                             Cfg_Done,
    output logic [1:0]                       Cfg_Err,
    output logic                             isConfig_Out,
    output logic [FIR_CONFIG_DATA_WIDTH-1:0] Data_Config_Out,
    input  logic                             isConfigACK_In,
    input  logic                             isConfigDone_In
);

    // Image length: coefficients, symmetry/control word, output scale (last).
    localparam int N   = FILTER_MAX_ORDER + 3;
    localparam int IW  = $clog2(N);
    localparam int AW1 = ADDR_WIDTH + 1;
    localparam int TW  = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [AW1-1:0] N_EXT    = AW1'(N);
    localparam logic [IW-1:0]  LAST_IDX = IW'(N - 1);
    localparam logic [IW-1:0]  ACK_IDX  = IW'(1);
    localparam logic [TW-1:0]  TO_LAST  = TW'(TIMEOUT_CYCLES - 1);

    localparam logic [1:0] ERR_OK     = 2'b00;
    localparam logic [1:0] ERR_NO_ACK = 2'b01;
    localparam logic [1:0] ERR_TMO    = 2'b10;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        REQ       = 3'd1,
        STREAM    = 3'd2,
        WAIT_DONE = 3'd3,
        FINISH    = 3'd4
    } state_t;

    state_t                           state_r;
    state_t                           state_s;
    logic [IW-1:0]                    idx_r;
    logic [IW-1:0]                    idx_s;
    logic [TW-1:0]                    tmo_r;
    logic [TW-1:0]                    tmo_s;
    logic [1:0]                       err_s;
    logic                             load_s;
    logic                             wr_ok_s;
    logic [FIR_CONFIG_DATA_WIDTH-1:0] image_r [0:N-1];

    // Host writes land only while idle and inside the image.
    assign wr_ok_s = Cfg_Wr_En && ({1'b0, Cfg_Wr_Addr} < N_EXT) && !Cfg_Busy;

    // Image buffer: deliberately not reset so the image survives a reset.
    always_ff @(posedge CLK) begin
        if (wr_ok_s) begin
            image_r[Cfg_Wr_Addr[IW-1:0]] <= Cfg_Wr_Data;
        end
    end

    // Next-state, stream index, timeout counter and error code.
    always_comb begin
        state_s = state_r;
        idx_s   = idx_r;
        tmo_s   = tmo_r;
        err_s   = Cfg_Err;
        load_s  = 1'b0;
        case (state_r)
            IDLE: begin
                if (Cfg_Start) begin
                    state_s = REQ;
                    err_s   = ERR_OK;
                end else begin
                    state_s = IDLE;
                end
            end
            REQ: begin
                idx_s   = {IW{1'b0}};
                state_s = STREAM;
            end
            STREAM: begin
                // ACK must be visible at the end of the second stream cycle,
                // i.e. one cycle after FIR control sampled the request.
                if ((idx_r == ACK_IDX) && !isConfigACK_In) begin
                    err_s   = ERR_NO_ACK;
                    state_s = FINISH;
                end else begin
                    load_s = 1'b1;
                    if (idx_r == LAST_IDX) begin
                        tmo_s   = {TW{1'b0}};
                        state_s = WAIT_DONE;
                    end else begin
                        idx_s = idx_r + IW'(1);
                    end
                end
            end
            WAIT_DONE: begin
                if (isConfigDone_In) begin
                    state_s = FINISH;
                end else if (tmo_r == TO_LAST) begin
                    err_s   = ERR_TMO;
                    state_s = FINISH;
                end else begin
                    tmo_s = tmo_r + TW'(1);
                end
            end
            FINISH: begin
                state_s = IDLE;
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // State, counters and all registered outputs.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_r         <= IDLE;
            idx_r           <= {IW{1'b0}};
            tmo_r           <= {TW{1'b0}};
            Cfg_Busy        <= 1'b0;
            Cfg_Done        <= 1'b0;
            Cfg_Err         <= ERR_OK;
            isConfig_Out    <= 1'b0;
            Data_Config_Out <= {FIR_CONFIG_DATA_WIDTH{1'b0}};
        end else begin
            state_r      <= state_s;
            idx_r        <= idx_s;
            tmo_r        <= tmo_s;
            Cfg_Err      <= err_s;
            isConfig_Out <= (state_r == REQ);
            Cfg_Busy     <= (state_r == REQ) || (state_r == STREAM) || (state_r == WAIT_DONE);
            Cfg_Done     <= (state_s == FINISH) && (state_r != FINISH);
            if (load_s) begin
                Data_Config_Out <= image_r[idx_r];
            end else begin
                Data_Config_Out <= Data_Config_Out;
            end
        end
    end

endmodule

// File: tb/tb_fir_cfg_loader.sv
// Directed bench for fir_cfg_loader with a small FIR-control handshake model.
// Small image (FILTER_MAX_ORDER=4, N=7) and TIMEOUT_CYCLES=8.
module tb_fir_cfg_loader;

    localparam int W  = 16;
    localparam int FO = 4;
    localparam int N  = FO + 3;
    localparam int AW = 4;
    localparam int TO = 8;

    // Edge numbers relative to the edge that samples Cfg_Start.
    localparam int DONE_OK  = N + 4;
    localparam int DONE_ACK = 3;
    localparam int DONE_TMO = N + 1 + TO;

    logic          CLK = 1'b0;
    logic          nRST;
    logic          Cfg_Wr_En;
    logic [AW-1:0] Cfg_Wr_Addr;
    logic [W-1:0]  Cfg_Wr_Data;
    logic          Cfg_Start;
    logic          Cfg_Busy;
    logic          Cfg_Done;
    logic [1:0]    Cfg_Err;
    logic          isConfig_Out;
    logic [W-1:0]  Data_Config_Out;
    logic          isConfigACK_In;
    logic          isConfigDone_In;

    int errs   = 0;
    int checks = 0;

    // FIR control model controls
    bit   ack_en;
    bit   done_en;
    logic rx_on;
    int   rx_cnt;
    logic done_pend;

    logic [W-1:0] exp_img [0:N-1];

    fir_cfg_loader #(
        .FIR_CONFIG_DATA_WIDTH(W),
        .FILTER_MAX_ORDER(FO),
        .ADDR_WIDTH(AW),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .CLK(CLK),
        .nRST(nRST),
        .Cfg_Wr_En(Cfg_Wr_En),
        .Cfg_Wr_Addr(Cfg_Wr_Addr),
        .Cfg_Wr_Data(Cfg_Wr_Data),
        .Cfg_Start(Cfg_Start),
        .Cfg_Busy(Cfg_Busy),
        .Cfg_Done(Cfg_Done),
        .Cfg_Err(Cfg_Err),
        .isConfig_Out(isConfig_Out),
        .Data_Config_Out(Data_Config_Out),
        .isConfigACK_In(isConfigACK_In),
        .isConfigDone_In(isConfigDone_In)
    );

    always #5 CLK = ~CLK;

    // FIR control: ACK after seeing the request, Done pulse one cycle after
    // the last word has been sampled (so the loader sees it at e(N+4)).
    always @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            isConfigACK_In  <= 1'b0;
            isConfigDone_In <= 1'b0;
            rx_on           <= 1'b0;
            rx_cnt          <= 0;
            done_pend       <= 1'b0;
        end else begin
            isConfigDone_In <= done_pend;
            done_pend       <= 1'b0;
            if (isConfig_Out) begin
                isConfigACK_In <= ack_en;
                rx_on          <= 1'b1;
                rx_cnt         <= 0;
            end else if (rx_on) begin
                rx_cnt <= rx_cnt + 1;
                if (rx_cnt == N - 1) begin
                    rx_on          <= 1'b0;
                    done_pend      <= done_en;
                    isConfigACK_In <= 1'b0;
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic write_word(input logic [AW-1:0] a, input logic [W-1:0] d);
        Cfg_Wr_En   = 1'b1;
        Cfg_Wr_Addr = a;
        Cfg_Wr_Data = d;
        tick();
        Cfg_Wr_En   = 1'b0;
    endtask

    // One transfer. full: whole image expected on the bus; inject: busy-time
    // writes and a stray start; b2b: request starts in FINISH and next IDLE;
    // pre: start was already sampled by the caller.
    task automatic do_run(input string tag, input int exp_done, input logic [1:0] exp_err,
                          input bit full, input bit inject, input bit b2b, input bit pre);
        logic [W-1:0] obs [0:N-1];
        int cfg_cnt  = 0;
        int cfg_edge = -1;
        int done_cnt = 0;
        int done_e   = -1;
        int idle_cfg = 0;
        logic busy1  = 1'b0;
        for (int k = 0; k < N; k++) obs[k] = 16'hDEAD;
        if (!pre) begin
            Cfg_Start = 1'b1;
            tick();
            Cfg_Start = 1'b0;
        end
        for (int e = 1; e <= 40; e++) begin
            tick();
            if (isConfig_Out) begin
                cfg_cnt++;
                if (cfg_edge < 0) cfg_edge = e;
            end
            if (e == 1) busy1 = Cfg_Busy;
            if (e >= 2 && e <= N + 1) obs[e-2] = Data_Config_Out;
            if (Cfg_Done) begin
                done_cnt++;
                if (done_e < 0) done_e = e;
            end
            if (inject) begin
                if (e == 3) begin
                    Cfg_Wr_En = 1'b1; Cfg_Wr_Addr = 4'd2; Cfg_Wr_Data = 16'hFFFF; Cfg_Start = 1'b1;
                end else if (e == 4) begin
                    Cfg_Wr_Addr = 4'd9; Cfg_Wr_Data = 16'hAAAA; Cfg_Start = 1'b0;
                end else begin
                    Cfg_Wr_En = 1'b0;
                end
            end
            if (b2b && done_e == e) Cfg_Start = 1'b1;
            if (done_e >= 0 && e >= done_e + 2) begin
                Cfg_Start = 1'b0;
                break;
            end
        end
        chk({tag, "_cfg_pulses"}, cfg_cnt, 1);
        chk({tag, "_cfg_edge"}, cfg_edge, 1);
        chk({tag, "_busy_e1"}, {31'd0, busy1}, 1);
        chk({tag, "_done_pulses"}, done_cnt, 1);
        chk({tag, "_done_edge"}, done_e, exp_done);
        chk({tag, "_err"}, {30'd0, Cfg_Err}, {30'd0, exp_err});
        if (full) begin
            for (int k = 0; k < N; k++) chk($sformatf("%s_word%0d", tag, k), obs[k], exp_img[k]);
        end else begin
            chk({tag, "_word0"}, obs[0], exp_img[0]);
            chk({tag, "_word1_held"}, obs[1], exp_img[0]);
        end
        if (!b2b) begin
            chk({tag, "_busy_end"}, {31'd0, Cfg_Busy}, 0);
            for (int e = 0; e < 12; e++) begin
                tick();
                if (isConfig_Out || Cfg_Busy) idle_cfg++;
            end
            chk({tag, "_no_extra"}, idle_cfg, 0);
        end
    endtask

    initial begin
        int stray;
        nRST        = 1'b0;
        Cfg_Wr_En   = 1'b0;
        Cfg_Wr_Addr = '0;
        Cfg_Wr_Data = '0;
        Cfg_Start   = 1'b0;
        ack_en      = 1'b1;
        done_en     = 1'b1;
        for (int k = 0; k < N; k++) exp_img[k] = 16'(16'h0011 * (k + 1));
        repeat (2) @(posedge CLK);
        #1;
        chk("rst_outputs", {Cfg_Busy, Cfg_Done, Cfg_Err, isConfig_Out, Data_Config_Out}, 0);
        nRST = 1'b1;
        tick();

        for (int k = 0; k < N; k++) write_word(AW'(k), exp_img[k]);
        tick();

        // Nominal transfer
        do_run("nom", DONE_OK, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0);

        // No ACK: stream abandoned after word 0
        ack_en = 1'b0;
        do_run("noack", DONE_ACK, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0);
        ack_en = 1'b1;

        // Done never returned: timeout
        done_en = 1'b0;
        do_run("tmo", DONE_TMO, 2'b10, 1'b1, 1'b0, 1'b0, 1'b0);
        done_en = 1'b1;

        // Successful run clears the error
        do_run("clr", DONE_OK, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0);

        // Busy-time writes and stray start are dropped
        do_run("inj", DONE_OK, 2'b00, 1'b1, 1'b1, 1'b0, 1'b0);
        do_run("post_inj", DONE_OK, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0);

        // Reset in the middle of the stream
        Cfg_Start = 1'b1;
        tick();
        Cfg_Start = 1'b0;
        repeat (4) tick();
        nRST = 1'b0;
        #1;
        chk("midrst_outputs", {Cfg_Busy, Cfg_Done, Cfg_Err, isConfig_Out, Data_Config_Out}, 0);
        stray = 0;
        for (int e = 0; e < 4; e++) begin
            tick();
            if (Cfg_Done) stray++;
        end
        nRST = 1'b1;
        for (int e = 0; e < 12; e++) begin
            tick();
            if (Cfg_Done || Cfg_Busy) stray++;
        end
        chk("midrst_no_done", stray, 0);
        do_run("after_rst", DONE_OK, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0);

        // Back-to-back: start in FINISH ignored, start in next IDLE accepted
        do_run("b2b1", DONE_OK, 2'b00, 1'b1, 1'b0, 1'b1, 1'b0);
        do_run("b2b2", DONE_OK, 2'b00, 1'b1, 1'b0, 1'b0, 1'b1);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
